// File: rtl/debug_pkg.sv
// Shared types and constants for the debug run-control block: FSM encodings, cmderr codes
// and the abstract regno map.
package debug_pkg;

  typedef enum logic [1:0] {
    StRunning,
    StHaltReq,
    StHalted,
    StResumeReq
  } run_state_e;

  typedef enum logic [1:0] {
    CmdIdle,
    CmdIssue,
    CmdWait
  } cmd_state_e;

  typedef enum logic [2:0] {
    CmdErrNone       = 3'd0,
    CmdErrBusy       = 3'd1,
    CmdErrNotSup     = 3'd2,
    CmdErrExcept     = 3'd3,
    CmdErrHaltResume = 3'd4,
    CmdErrOther      = 3'd7
  } cmderr_e;

  localparam logic [15:0] CsrBase  = 16'h0000;
  localparam logic [15:0] CsrLimit = 16'h0FFF;
  localparam logic [15:0] GprBase  = 16'h1000;
  localparam logic [15:0] GprLimit = 16'h101F;

  // Offset-from-base compares wrap below the base, so one unsigned test covers both bounds.
  function automatic logic regno_supported(logic [15:0] regno);
    return (16'(regno - CsrBase) <= 16'(CsrLimit - CsrBase)) ||
           (16'(regno - GprBase) <= 16'(GprLimit - GprBase));
  endfunction

endpackage

// File: rtl/debug_abs_cmd.sv
// Abstract command sequencer: regno decode, issue/wait FSM, cmderr/rdata registers and the
// shared watchdog counter (built only with DEBUG_RUN_CTRL_TIMEOUT_EN).
module debug_abs_cmd
  import debug_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  halted_i,
  input  logic                  run_wait_i,
  output logic                  timeout_o,
  output logic                  busy_o,
  input  logic                  cmd_accept_i,
  input  logic                  cmd_write_i,
  input  logic [15:0]           cmd_regno_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  cmd_done_o,
  output logic [DATA_WIDTH-1:0] cmd_rdata_o,
  output logic [2:0]            cmd_err_o,
  input  logic [2:0]            cmd_err_clr_i,
  output logic                  reg_req_o,
  input  logic                  reg_gnt_i,
  output logic                  reg_we_o,
  output logic [15:0]           reg_addr_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  input  logic                  reg_rvalid_i,
  input  logic [DATA_WIDTH-1:0] reg_rdata_i,
  input  logic                  reg_err_i
);

  cmd_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [15:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [2:0]            err_q, err_d;
  logic                  done_q, done_d;
  logic                  timeout;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    // Any error set below only happens with err_q == 0, so a set always overrides the clear.
    err_d   = err_q & ~cmd_err_clr_i;
    unique case (state_q)
      CmdIdle: begin
        if (cmd_accept_i) begin
          if (err_q != CmdErrNone) begin
            done_d = 1'b1;
          end else if (!halted_i) begin
            done_d = 1'b1;
            err_d  = CmdErrHaltResume;
          end else if (!regno_supported(cmd_regno_i)) begin
            done_d = 1'b1;
            err_d  = CmdErrNotSup;
          end else begin
            state_d = CmdIssue;
            we_d    = cmd_write_i;
            addr_d  = cmd_regno_i;
            wdata_d = cmd_wdata_i;
          end
        end
      end
      CmdIssue, CmdWait: begin
        if (timeout) begin
          state_d = CmdIdle;
          done_d  = 1'b1;
          err_d   = CmdErrOther;
        end else if (reg_rvalid_i && (reg_gnt_i || state_q == CmdWait)) begin
          state_d = CmdIdle;
          done_d  = 1'b1;
          if (!we_q) rdata_d = reg_rdata_i;
          if (reg_err_i) err_d = CmdErrExcept;
        end else if (reg_gnt_i && state_q == CmdIssue) begin
          state_d = CmdWait;
        end
      end
      default: state_d = CmdIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CmdIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

`ifdef DEBUG_RUN_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 10) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 10;
  logic [CntW-1:0] cnt_q;
  logic            cnt_en;

  assign cnt_en  = run_wait_i || (state_q != CmdIdle);
  assign timeout = cnt_en && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= (cnt_en && !timeout) ? cnt_q + CntW'(1) : '0;
    end
  end
`else
  // Watchdog inputs are inert when the counter is not built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = run_wait_i | (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

  assign timeout_o   = timeout;
  assign busy_o      = (state_q != CmdIdle);
  assign cmd_done_o  = done_q;
  assign cmd_rdata_o = rdata_q;
  assign cmd_err_o   = err_q;
  assign reg_req_o   = (state_q == CmdIssue);
  assign reg_we_o    = we_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;

endmodule

// File: rtl/debug_run_ctrl.sv
// Hart run control (halt/resume handshake, status) plus abstract command sequencing.
// Define DEBUG_RUN_CTRL_TIMEOUT_EN to build the halt/resume/command watchdog.
module debug_run_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  haltreq_i,
  input  logic                  resumereq_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [15:0]           cmd_regno_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  cmd_done_o,
  output logic [DATA_WIDTH-1:0] cmd_rdata_o,
  output logic [2:0]            cmd_err_o,
  input  logic [2:0]            cmd_err_clr_i,
  output logic                  debug_strobe_o,
  output logic                  core_resume_o,
  input  logic                  core_halted_i,
  output logic                  reg_req_o,
  input  logic                  reg_gnt_i,
  output logic                  reg_we_o,
  output logic [15:0]           reg_addr_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  input  logic                  reg_rvalid_i,
  input  logic [DATA_WIDTH-1:0] reg_rdata_i,
  input  logic                  reg_err_i,
  output logic                  allhalted_o,
  output logic                  allrunning_o,
  output logic                  allresumeack_o
);

  run_state_e state_q, state_d;
  logic       ack_q, ack_d;
  logic       pend_q, pend_d;
  logic       halted_q, running_q;
  logic       cmd_busy, cmd_accept, timeout, resume_req, resume_go;

  assign cmd_ready_o = (state_q == StRunning || state_q == StHalted) && !cmd_busy;
  assign cmd_accept  = cmd_valid_i && cmd_ready_o;
  assign resume_req  = resumereq_i && !haltreq_i;
  // A resume may not overlap a command; it is parked until the sequencer goes idle.
  assign resume_go   = (resume_req || pend_q) && !haltreq_i && !cmd_busy && !cmd_accept;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    pend_d  = pend_q;
    unique case (state_q)
      StRunning: begin
        if (core_halted_i) state_d = StHalted;
        else if (haltreq_i) state_d = StHaltReq;
      end
      StHaltReq: begin
        if (core_halted_i) state_d = StHalted;
        else if (timeout) state_d = StRunning;
      end
      StHalted: begin
        if (resume_go) begin
          state_d = StResumeReq;
          ack_d   = 1'b0;
          pend_d  = 1'b0;
        end else if (resume_req) begin
          pend_d = 1'b1;
        end
      end
      StResumeReq: begin
        if (!core_halted_i) begin
          state_d = StRunning;
          ack_d   = 1'b1;
        end else if (timeout) begin
          state_d = StHalted;
        end
      end
      default: state_d = StRunning;
    endcase
    if (haltreq_i) pend_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StRunning;
      ack_q     <= 1'b0;
      pend_q    <= 1'b0;
      halted_q  <= 1'b0;
      running_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      pend_q    <= pend_d;
      halted_q  <= (state_d == StHalted) || (state_d == StResumeReq);
      running_q <= (state_d == StRunning) || (state_d == StHaltReq);
    end
  end

  assign debug_strobe_o = (state_q == StHaltReq);
  assign core_resume_o  = (state_q == StResumeReq);
  assign allhalted_o    = halted_q;
  assign allrunning_o   = running_q;
  assign allresumeack_o = ack_q;

  debug_abs_cmd #(
    .DATA_WIDTH     (DATA_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_abs_cmd (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .halted_i      (state_q == StHalted),
    .run_wait_i    ((state_q == StHaltReq) || (state_q == StResumeReq)),
    .timeout_o     (timeout),
    .busy_o        (cmd_busy),
    .cmd_accept_i  (cmd_accept),
    .cmd_write_i   (cmd_write_i),
    .cmd_regno_i   (cmd_regno_i),
    .cmd_wdata_i   (cmd_wdata_i),
    .cmd_done_o    (cmd_done_o),
    .cmd_rdata_o   (cmd_rdata_o),
    .cmd_err_o     (cmd_err_o),
    .cmd_err_clr_i (cmd_err_clr_i),
    .reg_req_o     (reg_req_o),
    .reg_gnt_i     (reg_gnt_i),
    .reg_we_o      (reg_we_o),
    .reg_addr_o    (reg_addr_o),
    .reg_wdata_o   (reg_wdata_o),
    .reg_rvalid_i  (reg_rvalid_i),
    .reg_rdata_i   (reg_rdata_i),
    .reg_err_i     (reg_err_i)
  );

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Scoreboarded bench for debug_run_ctrl: directed scenarios then randomized run-control and
// abstract-command traffic against a high-level hart/cmderr model.
module tb_debug_run_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          haltreq_i = 1'b0, resumereq_i = 1'b0;
  logic          cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
  logic [15:0]   cmd_regno_i = '0;
  logic [DW-1:0] cmd_wdata_i = '0;
  logic          cmd_done_o;
  logic [DW-1:0] cmd_rdata_o;
  logic [2:0]    cmd_err_o;
  logic [2:0]    cmd_err_clr_i = '0;
  logic          debug_strobe_o, core_resume_o, core_halted_i = 1'b0;
  logic          reg_req_o, reg_gnt_i = 1'b0, reg_we_o;
  logic [15:0]   reg_addr_o;
  logic [DW-1:0] reg_wdata_o;
  logic          reg_rvalid_i = 1'b0;
  logic [DW-1:0] reg_rdata_i = '0;
  logic          reg_err_i = 1'b0;
  logic          allhalted_o, allrunning_o, allresumeack_o;

  always #5 clk_i = ~clk_i;

  debug_run_ctrl #(
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .haltreq_i      (haltreq_i),
    .resumereq_i    (resumereq_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_write_i    (cmd_write_i),
    .cmd_regno_i    (cmd_regno_i),
    .cmd_wdata_i    (cmd_wdata_i),
    .cmd_done_o     (cmd_done_o),
    .cmd_rdata_o    (cmd_rdata_o),
    .cmd_err_o      (cmd_err_o),
    .cmd_err_clr_i  (cmd_err_clr_i),
    .debug_strobe_o (debug_strobe_o),
    .core_resume_o  (core_resume_o),
    .core_halted_i  (core_halted_i),
    .reg_req_o      (reg_req_o),
    .reg_gnt_i      (reg_gnt_i),
    .reg_we_o       (reg_we_o),
    .reg_addr_o     (reg_addr_o),
    .reg_wdata_o    (reg_wdata_o),
    .reg_rvalid_i   (reg_rvalid_i),
    .reg_rdata_i    (reg_rdata_i),
    .reg_err_i      (reg_err_i),
    .allhalted_o    (allhalted_o),
    .allrunning_o   (allrunning_o),
    .allresumeack_o (allresumeack_o)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic [2:0]    err;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail = 0;
  bit            m_halted = 0;
  logic [2:0]    m_err = '0;
  logic [DW-1:0] m_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every cmd_done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && cmd_done_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got cmd_done_o=1, expected no completion (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("cmd_rdata", cmd_rdata_o, e.rdata);
        check("cmd_err", cmd_err_o, e.err);
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    resumereq_i = 1'b0;
  endtask

  function automatic logic [15:0] rand_regno();
    int c = $urandom_range(0, 2);
    if (c == 0) return 16'($urandom_range(0, 'h0FFF));
    if (c == 1) return 16'('h1000 + $urandom_range(0, 31));
    return 16'($urandom_range('h1020, 'hFFFF));
  endfunction

  function automatic bit will_access(input logic [15:0] regno);
    return m_err == 0 && m_halted &&
           (regno <= 16'h0FFF || (regno >= 16'h1000 && regno <= 16'h101F));
  endfunction

  task automatic do_cmd(input bit wr, input logic [15:0] regno, input logic [DW-1:0] wd,
                        input int gnt_dly, input int rv_dly, input bit rerr,
                        input logic [DW-1:0] rd, input bit resume_mid);
    exp_t e;
    bit   access, seen;
    access = will_access(regno);
    if (m_err != 0) begin
    end else if (!m_halted) begin
      m_err = 3'd4;
    end else if (!access) begin
      m_err = 3'd2;
    end else begin
      if (rerr) m_err = 3'd3;
      if (!wr) m_rdata = rd;
    end
    e.rdata = m_rdata;
    e.err   = m_err;
    sb.push_back(e);
    check("cmd_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_regno_i = regno;
    cmd_wdata_i = wd;
    tick();
    cmd_valid_i = 1'b0;
    cmd_regno_i = 16'($urandom);
    cmd_wdata_i = $urandom;
    check("reg_req", reg_req_o, access);
    if (access) begin
      check("reg_addr", reg_addr_o, regno);
      check("reg_we", reg_we_o, wr);
      if (wr) check("reg_wdata", reg_wdata_o, wd);
      check("cmd_ready_busy", cmd_ready_o, 0);
      if (resume_mid) resumereq_i = 1'b1;
      for (int i = 0; i < gnt_dly; i++) begin
        tick();
        check("reg_req_hold", {reg_req_o, reg_addr_o}, {1'b1, regno});
      end
      reg_gnt_i = 1'b1;
      if (rv_dly == 0) begin
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = rd;
        reg_err_i    = rerr;
      end
      tick();
      reg_gnt_i    = 1'b0;
      reg_rvalid_i = 1'b0;
      if (rv_dly > 0) begin
        check("reg_req_drop", reg_req_o, 0);
        for (int i = 1; i < rv_dly; i++) tick();
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = rd;
        reg_err_i    = rerr;
        tick();
        reg_rvalid_i = 1'b0;
      end
      reg_err_i   = 1'b0;
      reg_rdata_i = $urandom;
    end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (cmd_done_o) seen = 1;
      else tick();
    end
    check("cmd_done_seen", seen, 1);
    if (access && resume_mid) begin
      check("resume_after_done_low", core_resume_o, 0);
      tick();
      check("resume_after_done_high", core_resume_o, 1);
      core_halted_i = 1'b0;
      tick();
      check("pending_resume_running", {allrunning_o, allhalted_o, allresumeack_o}, 3'b101);
      m_halted = 0;
    end
  endtask

  task automatic do_halt(input int dly);
    int cnt = 0;
    haltreq_i = 1'b1;
    for (int i = 1; i <= dly; i++) begin
      tick();
      if (debug_strobe_o) cnt++;
    end
    core_halted_i = 1'b1;
    tick();
    haltreq_i = 1'b0;
    check("strobe_cycles", cnt, dly);
    check("strobe_drop", debug_strobe_o, 0);
    check("halt_status", {allhalted_o, allrunning_o}, 2'b10);
    m_halted = 1;
  endtask

  task automatic do_ebreak();
    core_halted_i = 1'b1;
    tick();
    check("ebreak_status", {allhalted_o, allrunning_o, debug_strobe_o}, 3'b100);
    m_halted = 1;
  endtask

  task automatic do_resume(input int dly);
    int cnt = 0;
    resumereq_i = 1'b1;
    for (int i = 1; i <= dly; i++) begin
      tick();
      if (core_resume_o) cnt++;
      if (i == 1) check("resumeack_cleared", allresumeack_o, 0);
    end
    core_halted_i = 1'b0;
    tick();
    check("resume_cycles", cnt, dly);
    check("resume_drop", core_resume_o, 0);
    check("resume_status", {allrunning_o, allhalted_o, allresumeack_o}, 3'b101);
    m_halted = 0;
  endtask

  task automatic do_halt_wins();
    haltreq_i   = 1'b1;
    resumereq_i = 1'b1;
    tick();
    tick();
    check("halt_wins", {core_resume_o, allhalted_o}, 2'b01);
    haltreq_i = 1'b0;
    tick();
  endtask

  task automatic clear_err(input logic [2:0] mask);
    cmd_err_clr_i = mask;
    tick();
    cmd_err_clr_i = '0;
    m_err = m_err & ~mask;
    check("err_clear", cmd_err_o, m_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_ready", cmd_ready_o, 1);
    check("rst_status", {allrunning_o, allhalted_o, allresumeack_o}, 3'b100);
    check("rst_ctrl", {debug_strobe_o, core_resume_o, reg_req_o, cmd_done_o}, 4'b0000);
    check("rst_err", cmd_err_o, 0);
    check("rst_rdata", cmd_rdata_o, 0);
    rst_ni = 1'b1;
    tick();

    // Running: haltresume error, then an errored-state command has no effect, then clear.
    do_cmd(0, 16'h1001, '0, 0, 0, 0, 32'h1111_1111, 0);
    do_cmd(1, 16'h0300, 32'h55, 0, 0, 0, '0, 0);
    clear_err(3'b111);
    do_halt(3);
    do_cmd(0, 16'h1005, '0, 1, 2, 0, 32'hDEAD_BEEF, 0);
    do_cmd(0, 16'h2000, '0, 0, 0, 0, '0, 0);
    do_cmd(1, 16'h0300, 32'hCAFE, 0, 0, 1, '0, 0);
    clear_err(3'b111);
    do_cmd(1, 16'h0300, 32'hCAFE, 0, 0, 1, '0, 0);
    clear_err(3'b111);
    do_cmd(1, 16'h101F, 32'h1234_5678, 2, 0, 0, '0, 0);
    do_halt_wins();
    do_cmd(0, 16'h0FFF, '0, 0, 1, 0, 32'hA5A5_0001, 1);
    do_halt(2);
    do_resume(2);
    do_ebreak();
    do_resume(1);

`ifdef DEBUG_RUN_CTRL_TIMEOUT_EN
    begin
      int cnt = 0;
      bit dropped = 0;
      haltreq_i = 1'b1;
      for (int i = 0; i < 40 && !dropped; i++) begin
        tick();
        if (debug_strobe_o) cnt++;
        else if (cnt > 0) dropped = 1;
      end
      haltreq_i = 1'b0;
      check("timeout_strobe_cycles", cnt, TO);
      check("timeout_running", {allrunning_o, allhalted_o}, 2'b10);
      tick();
    end
`endif

    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (!m_halted) begin
        if (r < 35) do_halt($urandom_range(1, 4));
        else if (r < 50) do_ebreak();
        else if (r < 70 && m_err != 0) clear_err(3'($urandom_range(1, 7)));
        else do_cmd(1'($urandom), rand_regno(), $urandom, 0, 0, 0, $urandom, 0);
      end else begin
        if (r < 15) do_resume($urandom_range(1, 3));
        else if (r < 40 && m_err != 0) clear_err(3'($urandom_range(1, 7)));
        else if (r < 45) do_halt_wins();
        else do_cmd(1'($urandom), rand_regno(), $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 3), ($urandom_range(0, 9) == 0), $urandom, (r >= 93));
      end
    end

    // Asynchronous reset mid-command and mid-halt-request.
    if (!m_halted) do_halt(1);
    clear_err(3'b111);
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b0;
    cmd_regno_i = 16'h1000;
    tick();
    cmd_valid_i = 1'b0;
    check("abort_req_pre", reg_req_o, 1);
    #2 rst_ni = 1'b0;
    #1 check("abort_req", {reg_req_o, cmd_ready_o, allrunning_o, allhalted_o}, 4'b0110);
    sb.delete();
    core_halted_i = 1'b0;
    m_halted = 0;
    m_err = '0;
    m_rdata = '0;
    tick();
    rst_ni = 1'b1;
    haltreq_i = 1'b1;
    tick();
    tick();
    check("abort_strobe_pre", debug_strobe_o, 1);
    #2 rst_ni = 1'b0;
    #1 check("abort_strobe", debug_strobe_o, 0);
    haltreq_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_run_ctrl.md
Name: debug_run_ctrl

Overview:
- Debug Module-side run-control and abstract-command sequencer for one hart.
- Turns dmcontrol-style haltreq/resumereq into the core's halt strobe and resume request, and tracks halted/running/resumeack status.
- Sequences abstract register-access commands onto the core's debug register port, only while the hart is halted.
- Sits between the DMI register file and the core's debug controller/CSR logic.

Parameters:
- DATA_WIDTH, 32, abstract data / register port width.
- TIMEOUT_CYCLES, 1023, halt/resume/register-access watchdog limit (optional feature only).

Ports:
- clk_i, in, 1, core clock.
- rst_ni, in, 1, reset; asynchronous, active-low.
- haltreq_i, in, 1, dmcontrol.haltreq level.
- resumereq_i, in, 1, one-cycle resume pulse.
- cmd_valid_i / cmd_ready_o, in/out, 1/1, abstract command handshake.
- cmd_write_i, in, 1, 1 = write register.
- cmd_regno_i, in, 16, abstract regno.
- cmd_wdata_i, in, DATA_WIDTH, write data.
- cmd_done_o, out, 1, one-cycle completion pulse.
- cmd_rdata_o, out, DATA_WIDTH, read data, held until next completion.
- cmd_err_o, out, 3, sticky cmderr.
- cmd_err_clr_i, in, 3, write-1-to-clear mask for cmderr.
- debug_strobe_o, out, 1, halt request to core; level.
- core_resume_o, out, 1, resume request to core; level.
- core_halted_i, in, 1, hart is in debug mode.
- reg_req_o / reg_gnt_i, out/in, 1/1, register access request.
- reg_we_o, out, 1, register access write enable.
- reg_addr_o, out, 16, register address (= regno).
- reg_wdata_o, out, DATA_WIDTH, register write data.
- reg_rvalid_i, in, 1, register response valid.
- reg_rdata_i, in, DATA_WIDTH, register read data.
- reg_err_i, in, 1, register access faulted.
- allhalted_o, out, 1, hart status: halted.
- allrunning_o, out, 1, hart status: running.
- allresumeack_o, out, 1, resume acknowledged.

Behaviour:
- Reset (async, rst_ni low): state RUNNING; all outputs 0 except allrunning_o=1 and cmd_ready_o=1.
- RUNNING:
  - haltreq_i=1 -> HALT_REQ next cycle; debug_strobe_o held 1.
  - HALT_REQ -> HALTED on the first cycle core_halted_i=1; strobe drops that same edge.
  - core_halted_i=1 while RUNNING without a request (ebreak/trigger) -> HALTED directly.
- HALTED:
  - resumereq_i=1 with haltreq_i=0 -> RESUME_REQ; allresumeack_o cleared the same edge.
  - resumereq_i is ignored while haltreq_i=1 (halt wins).
- RESUME_REQ: core_resume_o held 1 until core_halted_i=0 -> RUNNING; allresumeack_o set (sticky until next accepted resume).
- Command acceptance:
  - A command is accepted on the edge where cmd_valid_i && cmd_ready_o.
  - cmd_ready_o=1 only in RUNNING/HALTED with no command in flight.
- Command completion and cmderr:
  - Accepted while cmd_err_o!=0 -> no side effect; cmd_done_o next cycle.
  - Accepted while not HALTED -> cmd_err_o=4 (haltresume); cmd_done_o next cycle.
  - Regno outside 0x0000-0x0FFF (CSR) and 0x1000-0x101F (GPR) -> cmd_err_o=2 (notsupported); cmd_done_o next cycle.
- Valid command in HALTED -> CMD_ISSUE:
  - reg_req_o=1, held with stable we/addr/wdata until reg_gnt_i.
  - Then CMD_WAIT until reg_rvalid_i.
  - On response: cmd_rdata_o<=reg_rdata_i (reads only); cmd_err_o=3 if reg_err_i; cmd_done_o pulses; return to HALTED.
  - Grant and rvalid in the same cycle is legal: skip CMD_WAIT.
- resumereq_i or haltreq_i changes during CMD_ISSUE/CMD_WAIT: resumereq latched as pending; resume starts the cycle after cmd_done_o. Only one pending resume.
- Status outputs (registered):
  - allhalted_o=1 in HALTED/CMD_ISSUE/CMD_WAIT/RESUME_REQ.
  - allrunning_o=1 in RUNNING/HALT_REQ.
  - Never both set.
- cmd_err_o: first error wins (not overwritten); cleared bitwise by cmd_err_clr_i. Clear and set in the same cycle: set wins.
- Reset during any state aborts immediately: reg_req_o, debug_strobe_o and core_resume_o drop asynchronously.

Optional Feature:
- Macro: DEBUG_RUN_CTRL_TIMEOUT_EN.
- Defined: a shared 10-bit+ counter runs in HALT_REQ, RESUME_REQ and CMD_ISSUE/CMD_WAIT. On reaching TIMEOUT_CYCLES:
  - HALT_REQ -> RUNNING, strobe dropped.
  - RESUME_REQ -> HALTED, no resumeack.
  - CMD_* -> cmd_err_o=7 (other), cmd_done_o, reg_req_o dropped.
- Undefined: no counter; states wait indefinitely.

Decomposition:
- Package debug_pkg:
  - Run-control state encoding.
  - cmderr codes: NONE=0, BUSY=1, NOTSUP=2, EXCEPT=3, HALTRESUME=4, OTHER=7.
  - Regno range constants: CSR_BASE/LIMIT, GPR_BASE/LIMIT.
- One sub-module: debug_abs_cmd. Holds the command issue/wait FSM, regno decode, cmd_rdata_o/cmd_err_o registers, and the timeout counter. The top keeps run-control FSM and status.

Test Plan:
- haltreq_i=1, core_halted_i rises 3 cycles later -> debug_strobe_o high exactly those 3 cycles; allhalted_o=1, allrunning_o=0 next cycle.
- Halted, resumereq_i pulse, core_halted_i falls after 2 cycles -> core_resume_o high 2 cycles; allresumeack_o=1, allrunning_o=1.
- Halted, read regno 0x1005, reg_gnt_i after 1 cycle, reg_rvalid_i with 0xDEADBEEF 2 cycles later -> reg_addr_o=0x1005, cmd_done_o pulse, cmd_rdata_o=0xDEADBEEF, cmd_err_o=0.
- Running, command valid -> cmd_err_o=4, no reg_req_o. Second command -> done, no side effect. cmd_err_clr_i=3'b111 -> cmd_err_o=0.
- Halted, regno 0x2000 -> cmd_err_o=2. Write regno 0x0300 with reg_err_i=1 -> cmd_err_o stays 2 (first error wins).
- resumereq_i during CMD_WAIT -> core_resume_o rises the cycle after cmd_done_o. With DEBUG_RUN_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8, unanswered halt -> back to RUNNING after 8 cycles.
